// File: rtl/vga_fb_scanner.sv
// vga_fb_scanner: 640x480@60 raster scan-out of a byte-per-pixel 3-3-2 framebuffer.
// Each byte covers a (1<<SCALE_SH)-square block of pixels; a one-clock pulse marks the start of vblank.
module vga_fb_scanner #(
  parameter int FB_W     = 160,
  parameter int SCALE_SH = 2
) (
  input  logic        clk,
  input  logic        RST,
  output logic [15:0] vga_addr,
  output logic        vga_rden,
  input  logic [7:0]  vga_data,
  output logic [2:0]  vga_red,
  output logic [2:0]  vga_green,
  output logic [1:0]  vga_blue,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_intr
);

  localparam logic [9:0] H_VISIBLE  = 10'd640;
  localparam logic [9:0] H_SYNC_BEG = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd751;
  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] V_VISIBLE  = 10'd480;
  localparam logic [9:0] V_SYNC_BEG = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd491;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] V_ACT_LAST = 10'd479;
  localparam logic [15:0] FB_STRIDE = 16'(FB_W);

  logic        pix_en_r;
  logic [9:0]  h_r;
  logic [9:0]  v_r;
  logic        s1_active_r;
  logic        s1_hs_r;
  logic        s1_vs_r;

  logic        active_s;
  logic        hs_s;
  logic        vs_s;
  logic [15:0] x_s;
  logic [15:0] y_s;
  logic [15:0] addr_s;

  // Region decode and framebuffer byte address for the current raster position.
  always_comb begin
    active_s = (h_r < H_VISIBLE) && (v_r < V_VISIBLE);
    hs_s     = !((h_r >= H_SYNC_BEG) && (h_r <= H_SYNC_END));
    vs_s     = !((v_r >= V_SYNC_BEG) && (v_r <= V_SYNC_END));
    x_s      = {6'd0, h_r} >> SCALE_SH;
    y_s      = {6'd0, v_r} >> SCALE_SH;
    addr_s   = 16'(y_s * FB_STRIDE) + x_s;
  end

  // Pixel enable, raster counters, fetch stage (S1), pixel output stage and frame pulse.
  always_ff @(posedge clk) begin
    if (RST) begin
      pix_en_r    <= 1'b0;
      h_r         <= 10'd0;
      v_r         <= 10'd0;
      vga_addr    <= 16'd0;
      vga_rden    <= 1'b0;
      s1_active_r <= 1'b0;
      s1_hs_r     <= 1'b1;
      s1_vs_r     <= 1'b1;
      vga_red     <= 3'd0;
      vga_green   <= 3'd0;
      vga_blue    <= 2'd0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_intr  <= 1'b0;
    end else begin
      pix_en_r   <= ~pix_en_r;
      // The read strobe trails each tick by one clock, so memory samples the fresh address.
      vga_rden   <= pix_en_r;
      frame_intr <= pix_en_r && (h_r == H_LAST) && (v_r == V_ACT_LAST);
      if (pix_en_r) begin
        vga_addr    <= addr_s;
        s1_active_r <= active_s;
        s1_hs_r     <= hs_s;
        s1_vs_r     <= vs_s;
        if (h_r == H_LAST) begin
          h_r <= 10'd0;
          if (v_r == V_LAST) begin
            v_r <= 10'd0;
          end else begin
            v_r <= v_r + 10'd1;
          end
        end else begin
          h_r <= h_r + 10'd1;
        end
        if (s1_active_r) begin
          {vga_red, vga_green, vga_blue} <= vga_data;
        end else begin
          {vga_red, vga_green, vga_blue} <= 8'd0;
        end
        vga_hs <= s1_hs_r;
        vga_vs <= s1_vs_r;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scanner.sv
// Directed bench for vga_fb_scanner: table of post-reset raster checkpoints plus
// hand-written sequences for the bottom of the frame, vsync and mid-frame reset.
module tb_vga_fb_scanner;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] vga_addr;
  logic        vga_rden;
  logic [7:0]  vga_data = 8'h00;
  logic [2:0]  vga_red;
  logic [2:0]  vga_green;
  logic [1:0]  vga_blue;
  logic        vga_hs;
  logic        vga_vs;
  logic        frame_intr;
  logic [7:0]  mem_byte = 8'hE3;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          e;     // clock edge index counted from reset release
    logic [15:0] addr;
    logic        rden;
    logic [7:0]  rgb;
    logic        hs;
  } vec_t;

  vec_t tbl[$];

  vga_fb_scanner dut (
    .clk        (clk),
    .RST        (RST),
    .vga_addr   (vga_addr),
    .vga_rden   (vga_rden),
    .vga_data   (vga_data),
    .vga_red    (vga_red),
    .vga_green  (vga_green),
    .vga_blue   (vga_blue),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .frame_intr (frame_intr)
  );

  always #5 clk = ~clk;

  // Memory port model: fixed one-clock read latency.
  always @(posedge clk) begin
    if (vga_rden) vga_data <= mem_byte;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rgb_now();
    return {vga_red, vga_green, vga_blue};
  endfunction

  task automatic add(input int e, input int addr, input logic rden, input logic [7:0] rgb,
                     input logic hs);
    vec_t v;
    v.e = e; v.addr = 16'(addr); v.rden = rden; v.rgb = rgb; v.hs = hs;
    tbl.push_back(v);
  endtask

  // Called at the negedge where RST has just been released.
  task automatic run_table(input string tag);
    int prev = 0;
    foreach (tbl[i]) begin
      step(tbl[i].e - prev);
      prev = tbl[i].e;
      chk($sformatf("%s addr e%0d", tag, tbl[i].e), vga_addr, tbl[i].addr);
      chk($sformatf("%s rden e%0d", tag, tbl[i].e), vga_rden, tbl[i].rden);
      chk($sformatf("%s rgb e%0d", tag, tbl[i].e), rgb_now(), tbl[i].rgb);
      chk($sformatf("%s hs e%0d", tag, tbl[i].e), vga_hs, tbl[i].hs);
      chk($sformatf("%s vs e%0d", tag, tbl[i].e), vga_vs, 1);
      chk($sformatf("%s fi e%0d", tag, tbl[i].e), frame_intr, 0);
    end
  endtask

  // Called just after a tick edge; places the raster at (h,v) so that the next
  // tick edge acts on it, and returns just after that tick edge.
  task automatic force_hv(input logic [9:0] h, input logic [9:0] v);
    @(negedge clk);
    force dut.h_r = h;
    force dut.v_r = v;
    #1;
    release dut.h_r;
    release dut.v_r;
    step(2);
  endtask

  initial begin
    int cnt;
    // Edge index e = 2+2n is the n-th tick; pins then show raster position n-1.
    add(1,    0,   1'b0, 8'h00, 1'b1);
    add(2,    0,   1'b1, 8'h00, 1'b1);
    add(3,    0,   1'b0, 8'h00, 1'b1);
    add(4,    0,   1'b1, 8'hE3, 1'b1);
    add(8,    0,   1'b1, 8'hE3, 1'b1);
    add(10,   1,   1'b1, 8'hE3, 1'b1);
    add(16,   1,   1'b1, 8'hE3, 1'b1);
    add(18,   2,   1'b1, 8'hE3, 1'b1);
    add(1280, 159, 1'b1, 8'hE3, 1'b1);
    add(1282, 160, 1'b1, 8'hE3, 1'b1);
    add(1283, 160, 1'b0, 8'hE3, 1'b1);
    add(1284, 160, 1'b1, 8'h00, 1'b1);
    add(1314, 164, 1'b1, 8'h00, 1'b1);
    add(1316, 164, 1'b1, 8'h00, 1'b0);
    add(1506, 188, 1'b1, 8'h00, 1'b0);
    add(1508, 188, 1'b1, 8'h00, 1'b1);
    add(1602, 0,   1'b1, 8'h00, 1'b1);
    add(2914, 164, 1'b1, 8'h00, 1'b1);
    add(2916, 164, 1'b1, 8'h00, 1'b0);
    add(4516, 164, 1'b1, 8'h00, 1'b0);
    add(6402, 160, 1'b1, 8'h00, 1'b1);
    add(6404, 160, 1'b1, 8'hE3, 1'b1);

    // Reset held for three clocks.
    step(3);
    chk("rst hs", vga_hs, 1);
    chk("rst vs", vga_vs, 1);
    chk("rst rgb", rgb_now(), 0);
    chk("rst addr", vga_addr, 0);
    chk("rst rden", vga_rden, 0);
    chk("rst fi", frame_intr, 0);
    @(negedge clk);
    RST = 1'b0;
    run_table("fresh");

    // Last visible pixel of the frame, with a byte that exposes channel ordering.
    @(negedge clk);
    mem_byte = 8'h9C;
    step(1);
    force_hv(10'd639, 10'd479);
    chk("last addr", vga_addr, 19199);
    step(2);
    chk("last rgb", rgb_now(), 8'h9C);
    chk("last red", vga_red, 4);
    chk("last blue", vga_blue, 0);
    step(2);
    chk("blank rgb", rgb_now(), 0);
    @(negedge clk);
    mem_byte = 8'hE3;
    step(1);

    // Frame pulse at the (799,479) -> (0,480) wrap.
    force_hv(10'd799, 10'd479);
    chk("fi pulse", frame_intr, 1);
    chk("fi addr", vga_addr, 19239);
    step(1);
    chk("fi width", frame_intr, 0);
    cnt = 0;
    for (int i = 0; i < 1601; i++) begin
      step(1);
      if (frame_intr) cnt++;
    end
    chk("fi extra", cnt, 0);

    // Vertical sync: low for 1600 ticks, starting two ticks after (0,490).
    force_hv(10'd799, 10'd489);
    step(2);
    chk("vs before", vga_vs, 1);
    cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      step(2);
      if (!vga_vs) cnt++;
    end
    chk("vs low ticks", cnt, 1600);
    step(2);
    chk("vs after", vga_vs, 1);

    // Mid-frame reset at (300,200).
    force_hv(10'd300, 10'd200);
    step(2);
    chk("mid rgb", rgb_now(), 8'hE3);
    chk("mid addr", vga_addr, 8075);
    @(negedge clk);
    RST = 1'b1;
    step(1);
    chk("mrst addr", vga_addr, 0);
    chk("mrst hs", vga_hs, 1);
    chk("mrst vs", vga_vs, 1);
    chk("mrst rgb", rgb_now(), 0);
    chk("mrst rden", vga_rden, 0);
    @(negedge clk);
    RST = 1'b0;
    run_table("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
